// File: rtl/avalon_sdr_mover_if.sv
// Avalon-MM bus bundle between avalon_sdr_mover (master) and the SDRAM controller port (slave).
interface avalon_sdr_mover_if #(
    parameter int DATA_W = 16
);
    logic                avm_read;
    logic                avm_write;
    logic [31:0]         avm_address;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;
    logic                avm_waitrequest;

    modport master (
        output avm_read, avm_write, avm_address, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport slave (
        input  avm_read, avm_write, avm_address, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface

// File: rtl/avalon_sdr_mover.sv
// Avalon-MM block mover between a flat 32-bit register array and SDRAM,
// with pipelined reads bounded by an outstanding-read limit.
module avalon_sdr_mover #(
    parameter int DATA_W      = 16,
    parameter int MAX_NREAD   = 64,
    parameter int MAX_NWRITE  = 64,
    parameter int MAX_PENDING = 4,
    parameter int NELEM_W     = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_sdr_mover_if.master      avm,
    input  logic [31:0]             sdr_baseaddr,
    input  logic [NELEM_W-1:0]      sdr_nelems,
    input  logic [32*MAX_NWRITE-1:0] sdr_writedata,
    output logic [32*MAX_NREAD-1:0] sdr_readdata,
    input  logic                    sdr_readstart,
    input  logic                    sdr_writestart,
    output logic                    sdr_busy,
    output logic                    sdr_readend,
    output logic                    sdr_writeend,
    output logic                    sdr_err
);
    localparam int BEATS     = 32 / DATA_W;
    localparam int STEP      = DATA_W / 8;
    localparam int MAX_NELEM = (MAX_NREAD > MAX_NWRITE) ? MAX_NREAD : MAX_NWRITE;
    localparam int CNT_W     = $clog2(MAX_NELEM * BEATS + 1);
    localparam int PEND_W    = $clog2(MAX_PENDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [31:0]             r_base;
    logic [CNT_W-1:0]        r_total;
    logic [CNT_W-1:0]        r_iss;
    logic [CNT_W-1:0]        r_rcv;
    logic [PEND_W-1:0]       r_pend;
    logic                    r_op_wr;
    logic                    r_err;
    logic [32*MAX_NWRITE-1:0] r_wdata;
    logic [32*MAX_NREAD-1:0] r_rdata;

    logic                    w_start;
    logic                    w_zero;
    logic                    w_illegal;
    logic [CNT_W-1:0]        w_total;
    logic                    w_req_wr;
    logic                    w_req_rd;
    logic                    w_req;
    logic                    w_acc;
    logic                    w_acc_rd;
    logic                    w_rd_take;
    logic                    w_last_iss;
    logic                    w_last_rcv;

    assign w_start   = sdr_writestart | sdr_readstart;
    assign w_zero    = (sdr_nelems == '0);
    assign w_illegal = sdr_writestart ? (sdr_nelems > NELEM_W'(MAX_NWRITE))
                                      : (sdr_nelems > NELEM_W'(MAX_NREAD));
    // Only meaningful for legal counts, where the product always fits CNT_W.
    assign w_total   = CNT_W'(sdr_nelems) * CNT_W'(BEATS);

    assign w_req_wr   = (r_state == S_WRITE);
    assign w_req_rd   = (r_state == S_READ) && (r_pend < PEND_W'(MAX_PENDING));
    assign w_req      = w_req_wr | w_req_rd;
    assign w_acc      = w_req & ~avm.avm_waitrequest;
    assign w_acc_rd   = w_req_rd & ~avm.avm_waitrequest;
    assign w_rd_take  = avm.avm_readdatavalid && (r_rcv < r_total)
                        && ((r_state == S_READ) || (r_state == S_DRAIN));
    assign w_last_iss = (r_iss == r_total - 1'b1);
    assign w_last_rcv = (r_rcv == r_total - 1'b1);

    assign avm.avm_write      = w_req_wr;
    assign avm.avm_read       = w_req_rd;
    assign avm.avm_address    = r_base + 32'(r_iss) * 32'(STEP);
    assign avm.avm_writedata  = w_req_wr ? r_wdata[DATA_W*r_iss +: DATA_W] : '0;
    assign avm.avm_byteenable = w_req ? '1 : '0;

    assign sdr_busy     = (r_state != S_IDLE);
    assign sdr_readend  = (r_state == S_DONE) && !r_op_wr;
    assign sdr_writeend = (r_state == S_DONE) && r_op_wr;
    assign sdr_err      = (r_state == S_DONE) && r_err;
    assign sdr_readdata = r_rdata;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_zero || w_illegal) w_next = S_DONE;
                    else                     w_next = sdr_writestart ? S_WRITE : S_READ;
                end
            end
            S_WRITE: if (w_acc && w_last_iss)      w_next = S_DONE;
            S_READ:  if (w_acc && w_last_iss)      w_next = S_DRAIN;
            S_DRAIN: if (w_rd_take && w_last_rcv)  w_next = S_DONE;
            S_DONE:                                w_next = S_IDLE;
            default:                               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base  <= '0;
            r_total <= '0;
            r_iss   <= '0;
            r_rcv   <= '0;
            r_pend  <= '0;
            r_op_wr <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (r_state == S_IDLE) begin
            if (w_start) begin
                r_base  <= sdr_baseaddr;
                r_total <= w_total;
                r_iss   <= '0;
                r_rcv   <= '0;
                r_pend  <= '0;
                r_op_wr <= sdr_writestart;
                r_err   <= w_illegal;
                if (sdr_writestart) r_wdata <= sdr_writedata;
                else                r_rdata <= '0;
            end
        end else begin
            if (w_acc) r_iss <= r_iss + 1'b1;
            if (w_rd_take) begin
                r_rdata[DATA_W*r_rcv +: DATA_W] <= avm.avm_readdata;
                r_rcv <= r_rcv + 1'b1;
            end
            if (w_acc_rd && !w_rd_take)      r_pend <= r_pend + 1'b1;
            else if (!w_acc_rd && w_rd_take) r_pend <= r_pend - 1'b1;
        end
    end
endmodule

// File: tb/tb_avalon_sdr_mover.sv
// Self-checking bench for avalon_sdr_mover: Avalon slave model plus a transaction-level
// reference that predicts every bus/status output cycle by cycle.
module tb_avalon_sdr_mover;
    localparam int DW    = 16;
    localparam int NR    = 8;
    localparam int NW    = 8;
    localparam int MP    = 2;
    localparam int NEW   = 8;
    localparam int BEATS = 32 / DW;
    localparam int STEP  = DW / 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        sdr_baseaddr = '0;
    logic [NEW-1:0]     sdr_nelems = '0;
    logic [32*NW-1:0]   sdr_writedata = '0;
    logic [32*NR-1:0]   sdr_readdata;
    logic               sdr_readstart = 1'b0;
    logic               sdr_writestart = 1'b0;
    logic               sdr_busy, sdr_readend, sdr_writeend, sdr_err;

    avalon_sdr_mover_if #(.DATA_W(DW)) bus ();

    avalon_sdr_mover #(
        .DATA_W(DW), .MAX_NREAD(NR), .MAX_NWRITE(NW), .MAX_PENDING(MP), .NELEM_W(NEW)
    ) dut (
        .clk(clk), .reset(reset), .avm(bus),
        .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems),
        .sdr_writedata(sdr_writedata), .sdr_readdata(sdr_readdata),
        .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
        .sdr_busy(sdr_busy), .sdr_readend(sdr_readend),
        .sdr_writeend(sdr_writeend), .sdr_err(sdr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase 0 idle, 1 transferring, 2 end-pulse cycle.
    int                 m_phase = 0;
    bit                 m_wr, m_err;
    logic [31:0]        m_base;
    int                 m_total, m_iss, m_rcv;
    logic [32*NW-1:0]   m_wdata = '0;
    logic [32*NR-1:0]   m_rdata = '0;

    // Slave behaviour knobs and in-order response queue.
    int  q_due[$];
    int  q_idx[$];
    bit  sl_rand_wait = 0;
    int  sl_stall_beat = -1;
    int  sl_stall_n = 0;
    int  sl_lat = 1;
    bit  sl_fixed = 0;
    bit  sl_spur = 0;

    // Per-operation observations for the literal checks.
    int  rec_start_cyc, rec_end_cyc, rec_last_vcyc, rec_max_out, rec_acc_n;
    bit  rec_err_seen, rec_wend_seen, rec_rend_seen;
    logic [31:0] rec_addr[$];
    logic [DW-1:0] rec_data[$];

    always @(negedge clk) begin : cmp
        logic exp_rd, exp_wr, w, acc, v;
        logic [31:0] exp_addr, el;
        logic [DW-1:0] exp_wd, vdata;
        int b;
        cyc++;

        exp_wr   = (m_phase == 1) && m_wr;
        exp_rd   = (m_phase == 1) && !m_wr && (m_iss < m_total) && (m_iss - m_rcv < MP);
        exp_addr = m_base + 32'(m_iss * STEP);
        el       = m_wdata[32*(m_iss/BEATS) +: 32];
        exp_wd   = (m_iss % 2 == 1) ? el[31:16] : el[15:0];

        chk("avm_write", bus.avm_write, exp_wr);
        chk("avm_read", bus.avm_read, exp_rd);
        chk("avm_byteenable", bus.avm_byteenable, (exp_wr || exp_rd) ? 2'b11 : 2'b00);
        if (exp_wr || exp_rd) chk("avm_address", bus.avm_address, exp_addr);
        if (exp_wr) chk("avm_writedata", bus.avm_writedata, exp_wd);
        chk("sdr_busy", sdr_busy, m_phase != 0);
        chk("sdr_writeend", sdr_writeend, (m_phase == 2) && m_wr);
        chk("sdr_readend", sdr_readend, (m_phase == 2) && !m_wr);
        chk("sdr_err", sdr_err, (m_phase == 2) && m_err);
        chk("sdr_readdata", sdr_readdata, m_rdata);

        if (sdr_writeend || sdr_readend) begin
            rec_end_cyc  = cyc;
            rec_err_seen = sdr_err;
            if (sdr_writeend) rec_wend_seen = 1;
            if (sdr_readend)  rec_rend_seen = 1;
        end

        w = 0;
        if (bus.avm_read || bus.avm_write) begin
            if (m_phase == 1 && sl_stall_beat == m_iss && sl_stall_n > 0) begin
                w = 1;
                sl_stall_n--;
            end else if (sl_rand_wait) begin
                w = ($urandom_range(0, 3) == 0);
            end
        end
        bus.avm_waitrequest = w;
        acc = (bus.avm_read || bus.avm_write) && !w;

        v = 0;
        vdata = DW'($urandom);
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            v = 1;
            if (sl_fixed) vdata = 16'hA000 + 16'(q_idx[0]);
            void'(q_due.pop_front());
            void'(q_idx.pop_front());
        end else if (sl_spur && q_due.size() == 0 && (m_phase != 1 || m_wr)
                     && $urandom_range(0, 3) == 0) begin
            v = 1;
        end
        bus.avm_readdatavalid = v;
        bus.avm_readdata = vdata;
        if (acc && bus.avm_read) begin
            q_due.push_back(cyc + ((sl_lat > 0) ? sl_lat : int'($urandom_range(1, 6))));
            q_idx.push_back(m_iss);
        end

        if (reset) begin
            m_phase = 0;
            m_iss = 0;
            m_rcv = 0;
            m_rdata = '0;
        end else begin
            case (m_phase)
                0: if (sdr_writestart || sdr_readstart) begin
                    m_wr    = sdr_writestart;
                    m_base  = sdr_baseaddr;
                    m_total = int'(sdr_nelems) * BEATS;
                    m_iss   = 0;
                    m_rcv   = 0;
                    m_err   = int'(sdr_nelems) > (m_wr ? NW : NR);
                    if (m_wr) m_wdata = sdr_writedata;
                    else      m_rdata = '0;
                    m_phase = (sdr_nelems == 0 || m_err) ? 2 : 1;
                    rec_start_cyc = cyc;
                    rec_acc_n = 0; rec_max_out = 0; rec_last_vcyc = -1;
                    rec_wend_seen = 0; rec_rend_seen = 0; rec_err_seen = 0;
                    rec_addr.delete(); rec_data.delete();
                end
                1: begin
                    if (acc) begin
                        rec_addr.push_back(bus.avm_address);
                        rec_data.push_back(bus.avm_writedata);
                        rec_acc_n++;
                        m_iss++;
                    end
                    if (!m_wr && v && m_rcv < m_total) begin
                        b = m_rcv;
                        m_rdata[32*(b/2) + 16*(b%2) +: 16] = vdata;
                        m_rcv++;
                        rec_last_vcyc = cyc;
                    end
                    if (!m_wr && m_iss - m_rcv > rec_max_out) rec_max_out = m_iss - m_rcv;
                    if (m_wr ? (m_iss == m_total) : (m_rcv == m_total)) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    task automatic run_op(input bit wr, input bit rd, input int n, input logic [31:0] base,
                          input logic [32*NW-1:0] wd, input bit scramble, input bit wait_done);
        int t;
        @(posedge clk); #1;
        sdr_writestart = wr;
        sdr_readstart  = rd;
        sdr_nelems     = NEW'(n);
        sdr_baseaddr   = base;
        sdr_writedata  = wd;
        @(posedge clk); #1;
        sdr_writestart = 0;
        sdr_readstart  = 0;
        if (scramble) begin
            for (int i = 0; i < NW; i++) sdr_writedata[32*i +: 32] = $urandom;
            sdr_baseaddr = $urandom;
            sdr_nelems   = NEW'($urandom);
        end
        if (wait_done) begin
            t = 0;
            while (m_phase != 0 && t < 400) begin
                @(posedge clk); #1;
                t++;
            end
            chk("op_completes_in_time", t < 400, 1);
            if (t >= 400) begin
                reset = 1;
                @(posedge clk); #1;
                reset = 0;
            end
        end
    endtask

    task automatic drain_slave();
        int t;
        t = 0;
        while (q_due.size() > 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("slave_drained", q_due.size(), 0);
    endtask

    logic [32*NW-1:0] wd_a;
    logic [31:0] lit_a[4] = '{32'h100, 32'h102, 32'h104, 32'h106};
    logic [15:0] lit_d[4] = '{16'h2222, 16'h1111, 16'h4444, 16'h3333};

    initial begin : stim
        int t, k;
        logic [31:0] base;
        logic [32*NW-1:0] wd;
        bus.avm_waitrequest = 0;
        bus.avm_readdatavalid = 0;
        bus.avm_readdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", sdr_busy, 0);
        chk("reset_read", bus.avm_read, 0);
        chk("reset_write", bus.avm_write, 0);
        chk("reset_readdata", sdr_readdata, 0);
        reset = 0;

        wd_a = '0;
        wd_a[31:0]  = 32'h11112222;
        wd_a[63:32] = 32'h33334444;
        run_op(1, 0, 2, 32'h100, wd_a, 0, 1);
        chk("wr_end_latency", rec_end_cyc - rec_start_cyc, 5);
        chk("wr_err", rec_err_seen, 0);
        chk("wr_beats", rec_addr.size(), 4);
        for (int i = 0; i < 4; i++) if (rec_addr.size() > i) begin
            chk("wr_addr", rec_addr[i], lit_a[i]);
            chk("wr_data", rec_data[i], lit_d[i]);
        end

        sl_stall_beat = 1;
        sl_stall_n = 3;
        run_op(1, 0, 2, 32'h100, wd_a, 0, 1);
        sl_stall_beat = -1;
        chk("wr_stall_end_latency", rec_end_cyc - rec_start_cyc, 8);
        for (int i = 0; i < 4; i++) if (rec_addr.size() > i) begin
            chk("wr_stall_addr", rec_addr[i], lit_a[i]);
            chk("wr_stall_data", rec_data[i], lit_d[i]);
        end

        sl_lat = 5;
        sl_fixed = 1;
        run_op(0, 1, 4, 32'h2000, '0, 0, 1);
        sl_fixed = 0;
        chk("rd_max_outstanding", rec_max_out, MP);
        chk("rd_data", sdr_readdata[127:0],
            {32'hA007A006, 32'hA005A004, 32'hA003A002, 32'hA001A000});
        chk("rd_end_after_last_beat", rec_end_cyc, rec_last_vcyc + 1);
        chk("rd_end_kind", {rec_rend_seen, rec_wend_seen}, 2'b10);

        run_op(0, 1, 0, 32'h40, '0, 0, 1);
        chk("rd_zero_latency", rec_end_cyc - rec_start_cyc, 1);
        chk("rd_zero_err", rec_err_seen, 0);
        chk("rd_zero_traffic", rec_acc_n, 0);
        run_op(0, 1, NR + 1, 32'h40, '0, 0, 1);
        chk("rd_ovf_latency", rec_end_cyc - rec_start_cyc, 1);
        chk("rd_ovf_err", rec_err_seen, 1);
        chk("rd_ovf_traffic", rec_acc_n, 0);
        run_op(1, 0, NW + 1, 32'h40, wd_a, 0, 1);
        chk("wr_ovf_err", rec_err_seen, 1);

        for (int i = 0; i < NW; i++) wd[32*i +: 32] = $urandom;
        run_op(1, 1, 3, 32'h40, wd, 1, 1);
        chk("both_start_kind", {rec_rend_seen, rec_wend_seen}, 2'b01);
        chk("both_start_beats", rec_acc_n, 6);

        sl_lat = 6;
        run_op(0, 1, 4, 32'h300, '0, 0, 0);
        t = 0;
        while (m_iss < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_mid_reached_two", m_iss, 2);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("rst_mid_read_low", bus.avm_read, 0);
        chk("rst_mid_busy_low", sdr_busy, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_no_readend", rec_rend_seen, 0);
        chk("rst_mid_readdata_zero", sdr_readdata, 0);
        drain_slave();

        sl_lat = 0;
        sl_rand_wait = 1;
        sl_spur = 1;
        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 7);
            for (int i = 0; i < NW; i++) wd[32*i +: 32] = $urandom;
            base = {$urandom_range(0, 3) == 0 ? 28'hFFFFFFF : 28'($urandom), 3'($urandom), 1'b0};
            run_op(k >= 4 || k == 0, k < 4, $urandom_range(0, NR + 1), base, wd,
                   1'($urandom), 1);
            drain_slave();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
